sram_arbiter: RTL and testbench

//  Shares the single 64x8 scratch SRAM macro between two requesters.

---
 rtl/sram_arbiter_if.sv | 48 ++++
 rtl/sram_arbiter.sv | 136 +++++++++++++
 tb/tb_sram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Bus bundle between sram_arbiter, its two requesters and the 64x8 scratch SRAM.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) ();

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_ack;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_ack;

  logic [DATA_W-1:0] rdata;
  logic              busy;

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_in;
  logic [DATA_W-1:0] sram_out;
  logic              sram_gwe;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  sram_out,
    output a_gnt, a_ack, b_gnt, b_ack,
    output rdata, busy,
    output sram_addr, sram_in, sram_gwe
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output sram_out,
    input  a_gnt, a_ack, b_gnt, b_ack,
    input  rdata, busy,
    input  sram_addr, sram_in, sram_gwe
  );

endinterface

// File: rtl/sram_arbiter.sv
// Two-port req/gnt/ack arbiter owning the scratch SRAM pins; round-robin by default,
// strict port-A priority when SRAM_ARB_PRIO_EN is defined.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StRdCap} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;   // 1: port B owns the current access
  logic              a_gnt_q, a_gnt_d;
  logic              b_gnt_q, b_gnt_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pick_b;
  logic              win_we;

`ifdef SRAM_ARB_PRIO_EN
  always_comb begin
    pick_b = ~bus.a_req;
  end
`else
  logic last_q, last_d;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    pick_b = bus.b_req & (~bus.a_req | ~last_q);
  end
`endif

  assign win_we = pick_b ? bus.b_we : bus.a_we;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifndef SRAM_ARB_PRIO_EN
    last_d  = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.a_req || bus.b_req) begin
          owner_d = pick_b;
          a_gnt_d = ~pick_b;
          b_gnt_d = pick_b;
          addr_d  = pick_b ? bus.b_addr : bus.a_addr;
          wdata_d = pick_b ? bus.b_wdata : bus.a_wdata;
          state_d = win_we ? StWr : StRd;
`ifndef SRAM_ARB_PRIO_EN
          last_d  = pick_b;
`endif
        end
      end
      StWr: begin
        a_ack_d = ~owner_q;
        b_ack_d = owner_q;
        state_d = StIdle;
      end
      StRd: begin
        // SRAM registers the address on this edge; data appears next cycle.
        state_d = StRdCap;
      end
      StRdCap: begin
        rdata_d = bus.sram_out;
        a_ack_d = ~owner_q;
        b_ack_d = owner_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      owner_q <= 1'b0;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
`ifndef SRAM_ARB_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
      a_ack_q <= a_ack_d;
      b_ack_q <= b_ack_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifndef SRAM_ARB_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign bus.a_gnt     = a_gnt_q;
  assign bus.b_gnt     = b_gnt_q;
  assign bus.a_ack     = a_ack_q;
  assign bus.b_ack     = b_ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.sram_addr = addr_q;
  assign bus.sram_in   = wdata_q;
  // Decoded straight from state so reset removes the strobe without a clock edge.
  assign bus.sram_gwe  = (state_q == StWr);

  a_gnt_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(a_gnt_q && b_gnt_q));
  a_ack_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(a_ack_q && b_ack_q));
  a_gnt_ack:  assert property (@(posedge clk_i) disable iff (rst_i)
                               !((a_gnt_q && a_ack_q) || (b_gnt_q && b_ack_q)));

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter against a transaction-level reference model.
module tb_sram_arbiter;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // Synchronous-read SRAM macro model
  logic [DW-1:0] sram_mem [64];
  always @(posedge clk) begin
    if (bus.sram_gwe) sram_mem[bus.sram_addr] <= bus.sram_in;
    bus.sram_out <= sram_mem[bus.sram_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one access in flight; a sampled request at edge n completes
  // at edge n+1 (write) or n+2 (read); the next request is sampled after that.
  logic [DW-1:0] ref_mem [64];
  int            edge_n;
  bit            m_active, m_we, m_owner_b, m_last_b;
  int            m_ack_edge;
  logic [AW-1:0] m_addr, m_sram_addr;
  logic [DW-1:0] m_wdata, m_sram_in, m_rdata;
  bit            e_gnt_a, e_gnt_b, e_ack_a, e_ack_b;

  task automatic model_reset();
    m_active    = 1'b0;
    m_last_b    = 1'b1;
    m_rdata     = '0;
    m_sram_addr = '0;
    m_sram_in   = '0;
    {e_gnt_a, e_gnt_b, e_ack_a, e_ack_b} = '0;
  endtask

  task automatic model_edge();
    bit pick_b;
    edge_n++;
    {e_gnt_a, e_gnt_b, e_ack_a, e_ack_b} = '0;
    if (m_active && edge_n == m_ack_edge) begin
      if (m_owner_b) e_ack_b = 1'b1;
      else           e_ack_a = 1'b1;
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      m_rdata = ref_mem[m_addr];
      m_active = 1'b0;
    end else if (!m_active && (bus.a_req || bus.b_req)) begin
`ifdef SRAM_ARB_PRIO_EN
      pick_b = !bus.a_req;
`else
      pick_b = (bus.a_req && bus.b_req) ? !m_last_b : bus.b_req;
`endif
      m_last_b    = pick_b;
      m_owner_b   = pick_b;
      m_we        = pick_b ? bus.b_we : bus.a_we;
      m_addr      = pick_b ? bus.b_addr : bus.a_addr;
      m_wdata     = pick_b ? bus.b_wdata : bus.a_wdata;
      m_sram_addr = m_addr;
      m_sram_in   = m_wdata;
      m_active    = 1'b1;
      m_ack_edge  = edge_n + (m_we ? 1 : 2);
      if (pick_b) e_gnt_b = 1'b1;
      else        e_gnt_a = 1'b1;
    end
  endtask

  task automatic compare_outputs();
    check("a_gnt", 32'(bus.a_gnt), 32'(e_gnt_a));
    check("b_gnt", 32'(bus.b_gnt), 32'(e_gnt_b));
    check("a_ack", 32'(bus.a_ack), 32'(e_ack_a));
    check("b_ack", 32'(bus.b_ack), 32'(e_ack_b));
    check("busy", 32'(bus.busy), 32'(m_active));
    check("sram_gwe", 32'(bus.sram_gwe), 32'(m_active && m_we));
    check("rdata", 32'(bus.rdata), 32'(m_rdata));
    check("sram_addr", 32'(bus.sram_addr), 32'(m_sram_addr));
    check("sram_in", 32'(bus.sram_in), 32'(m_sram_in));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) {e_gnt_a, e_gnt_b, e_ack_a, e_ack_b} = '0;
    else     model_edge();
    compare_outputs();
  endtask

  function automatic logic pick_sig(input int sel);
    case (sel)
      0:       return bus.a_gnt;
      1:       return bus.b_gnt;
      2:       return bus.a_ack;
      default: return bus.b_ack;
    endcase
  endfunction

  // sel: 0 a_gnt, 1 b_gnt, 2 a_ack, 3 b_ack
  task automatic wait_for(input int sel, input string tag);
    int guard = 0;
    do begin
      tick();
      guard++;
    end while (!pick_sig(sel) && guard < 12);
    check(tag, 32'(pick_sig(sel)), 32'd1);
  endtask

  task automatic access(input bit pb, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output int lat, output logic [DW-1:0] rd);
    int guard = 0;
    lat = 0;
    rd  = '0;
    if (pb) begin bus.b_req = 1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data; end
    else    begin bus.a_req = 1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data; end
    do begin
      tick();
      guard++;
    end while (!pick_sig(pb ? 1 : 0) && guard < 20);
    check("access_gnt", 32'(pick_sig(pb ? 1 : 0)), 32'd1);
    if (!pick_sig(pb ? 1 : 0)) return;
    lat = 1;
    // Disturb the request fields; the access must use what was latched at the grant.
    if (pb) begin bus.b_req = 0; bus.b_addr = ~addr; bus.b_wdata = ~data; end
    else    begin bus.a_req = 0; bus.a_addr = ~addr; bus.a_wdata = ~data; end
    guard = 0;
    do begin
      tick();
      lat++;
      guard++;
    end while (!pick_sig(pb ? 3 : 2) && guard < 10);
    check("access_ack", 32'(pick_sig(pb ? 3 : 2)), 32'd1);
    rd = bus.rdata;
  endtask

  bit pend_a, pend_b;

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(3, 0) == 0) return AW'($urandom);
    return AW'($urandom_range(7, 0));
  endfunction

  task automatic drive_random();
    if (bus.a_gnt) begin
      pend_a = 0;
      bus.a_addr = AW'($urandom);
      bus.a_wdata = DW'($urandom);
      bus.a_req = 0;
    end
    if (!pend_a && $urandom_range(2, 0) == 0) begin
      pend_a = 1; bus.a_req = 1; bus.a_we = 1'($urandom_range(1, 0));
      bus.a_addr = rand_addr(); bus.a_wdata = DW'($urandom);
    end
    if (bus.b_gnt) begin
      pend_b = 0;
      bus.b_addr = AW'($urandom);
      bus.b_wdata = DW'($urandom);
      bus.b_req = 0;
    end
    if (!pend_b && $urandom_range(2, 0) == 0) begin
      pend_b = 1; bus.b_req = 1; bus.b_we = 1'($urandom_range(1, 0));
      bus.b_addr = rand_addr(); bus.b_wdata = DW'($urandom);
    end
  endtask

  int            lat;
  logic [DW-1:0] rd;
  bit            grant_q[$];
  int            n_a, n_b;

  initial begin
    {bus.a_req, bus.a_we, bus.b_req, bus.b_we} = '0;
    bus.a_addr = '0; bus.a_wdata = '0; bus.b_addr = '0; bus.b_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      ref_mem[i]  = DW'(i * 37 + 5);
      sram_mem[i] <= DW'(i * 37 + 5);
    end
    edge_n = 0;
    model_reset();
    repeat (2) tick();
    rst = 0;

    // Write then read on A alone
    access(1'b0, 1'b1, 6'h05, 8'hA5, lat, rd);
    check("t1_wr_latency", 32'(lat), 32'd2);
    access(1'b0, 1'b0, 6'h05, 8'h00, lat, rd);
    check("t1_rd_latency", 32'(lat), 32'd3);
    check("t1_rdata", 32'(rd), 32'hA5);

    // Back-to-back writes on B with b_req held, at both address extremes
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 6'h3F; bus.b_wdata = 8'h11;
    wait_for(1, "t3_gnt1");
    bus.b_addr = 6'h00; bus.b_wdata = 8'h22;
    wait_for(3, "t3_ack1");
    tick();
    check("t3_regnt_after_ack", 32'(bus.b_gnt), 32'd1);
    bus.b_req = 0;
    wait_for(3, "t3_ack2");
    access(1'b1, 1'b0, 6'h3F, 8'h00, lat, rd);
    check("t3_rd_3f", 32'(rd), 32'h11);
    access(1'b1, 1'b0, 6'h00, 8'h00, lat, rd);
    check("t3_rd_00", 32'(rd), 32'h22);

    // Simultaneous held reads right after reset
    rst = 1; model_reset(); tick(); rst = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 6'h05;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 6'h3F;
    repeat (16) begin
      tick();
      if (bus.a_gnt) grant_q.push_back(1'b0);
      if (bus.b_gnt) grant_q.push_back(1'b1);
      if (bus.a_ack) check("t2_a_rdata", 32'(bus.rdata), 32'hA5);
      if (bus.b_ack) check("t2_b_rdata", 32'(bus.rdata), 32'h11);
    end
    bus.a_req = 0; bus.b_req = 0;
    check("t2_ngrants", 32'(grant_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < grant_q.size(); i++) begin
`ifdef SRAM_ARB_PRIO_EN
      check("t2_grant_order", 32'(grant_q[i]), 32'd0);
`else
      check("t2_grant_order", 32'(grant_q[i]), 32'(i % 2));
`endif
    end
    repeat (3) tick();

    // Reset asserted during the write cycle
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 6'h09; bus.a_wdata = 8'h77;
    wait_for(0, "t4_gnt");
    bus.a_req = 0;
    check("t4_gwe_before", 32'(bus.sram_gwe), 32'd1);
    rst = 1;
    #1;
    check("t4_gwe_async", 32'(bus.sram_gwe), 32'd0);
    check("t4_busy_async", 32'(bus.busy), 32'd0);
    model_reset();
    repeat (2) tick();
    rst = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 6'h09;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 6'h01;
    tick();
    check("t4_tie_after_reset", 32'(bus.a_gnt), 32'd1);
    bus.a_req = 0; bus.b_req = 0;
    repeat (4) tick();
    access(1'b0, 1'b0, 6'h09, 8'h00, lat, rd);
    check("t4_write_aborted", 32'(rd), 32'(DW'(9 * 37 + 5)));

`ifdef SRAM_ARB_PRIO_EN
    // Strict priority: B starves while A holds its request
    n_a = 0; n_b = 0;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 6'h02;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 6'h03;
    repeat (12) begin
      tick();
      if (bus.a_gnt) n_a++;
      if (bus.b_gnt) n_b++;
    end
    check("t5_b_starved", 32'(n_b), 32'd0);
    check("t5_a_granted", 32'(n_a >= 3), 32'd1);
    bus.a_req = 0;
    wait_for(1, "t5_b_after_drop");
    bus.b_req = 0;
    repeat (3) tick();
`endif

    // Randomized traffic on both ports
    pend_a = 0; pend_b = 0;
    repeat (2000) begin
      drive_random();
      tick();
    end
    bus.a_req = 0; bus.b_req = 0;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
